// File: rtl/pipeline_ctrl_if.sv
// Pipeline control bundle: hazard/handshake inputs toward the
// controller, stage enables/flushes and status back out.
interface pipeline_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             load_use_stall;
    logic             branch_taken;
    logic             ex_mc_start;
    logic             halt_req;
    logic             resume;
    logic             mem_req;
    logic             mem_ready;
    logic             pc_en;
    logic             if_id_en;
    logic             id_ex_en;
    logic             ex_mem_en;
    logic             mem_wb_en;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_flush;
    logic             halted;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output load_use_stall, branch_taken, ex_mc_start,
        output halt_req, resume, mem_req, mem_ready,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        input  if_id_flush, id_ex_flush, ex_mem_flush,
        input  halted, stall_cycles
    );

    modport slave (
        input  load_use_stall, branch_taken, ex_mc_start,
        input  halt_req, resume, mem_req, mem_ready,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        output if_id_flush, id_ex_flush, ex_mem_flush,
        output halted, stall_cycles
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: stage enables/flushes for hazards,
// multicycle EX ops, halt drain and memory back-pressure.
module pipeline_ctrl #(
    parameter int MC_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    pipeline_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_RUN,
        S_MC_WAIT,
        S_DRAIN,
        S_HALTED
    } state_t;

    localparam logic [7:0] MC_INIT = 8'(MC_LATENCY - 2);
    localparam logic [CNT_W-1:0] STALL_MAX = '1;

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic mem_stall;
    logic pc_en_c, if_id_en_c, id_ex_en_c, ex_mem_en_c, mem_wb_en_c;
    logic if_id_fl_c, id_ex_fl_c, ex_mem_fl_c, halted_c;

    assign mem_stall = bus.mem_req & ~bus.mem_ready;

    // Next state, counter and stage controls; memory stall freezes all
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_en_c     = 1'b1;
        if_id_en_c  = 1'b1;
        id_ex_en_c  = 1'b1;
        ex_mem_en_c = 1'b1;
        mem_wb_en_c = 1'b1;
        if_id_fl_c  = 1'b0;
        id_ex_fl_c  = 1'b0;
        ex_mem_fl_c = 1'b0;
        halted_c    = 1'b0;
        if (mem_stall) begin
            pc_en_c     = 1'b0;
            if_id_en_c  = 1'b0;
            id_ex_en_c  = 1'b0;
            ex_mem_en_c = 1'b0;
            mem_wb_en_c = 1'b0;
            halted_c    = (state_q == S_HALTED);
        end else begin
            unique case (state_q)
                S_RUN: begin
                    if (bus.halt_req) begin
                        pc_en_c    = 1'b0;
                        if_id_fl_c = 1'b1;
                        id_ex_fl_c = 1'b1;
                        state_d    = S_DRAIN;
                        cnt_d      = 8'd1;
                    end else if (bus.ex_mc_start) begin
                        pc_en_c     = 1'b0;
                        if_id_en_c  = 1'b0;
                        id_ex_en_c  = 1'b0;
                        ex_mem_fl_c = 1'b1;
                        state_d     = S_MC_WAIT;
                        cnt_d       = MC_INIT;
                    end else if (bus.branch_taken) begin
                        if_id_fl_c = 1'b1;
                        id_ex_fl_c = 1'b1;
                    end else if (bus.load_use_stall) begin
                        pc_en_c    = 1'b0;
                        if_id_en_c = 1'b0;
                        id_ex_fl_c = 1'b1;
                    end
                end
                S_MC_WAIT: begin
                    if (cnt_q != 8'd0) begin
                        pc_en_c     = 1'b0;
                        if_id_en_c  = 1'b0;
                        id_ex_en_c  = 1'b0;
                        ex_mem_fl_c = 1'b1;
                        cnt_d       = cnt_q - 8'd1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
                S_DRAIN: begin
                    pc_en_c    = 1'b0;
                    if_id_fl_c = 1'b1;
                    id_ex_fl_c = 1'b1;
                    if (cnt_q == 8'd0) begin
                        state_d = S_HALTED;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                S_HALTED: begin
                    pc_en_c     = 1'b0;
                    if_id_en_c  = 1'b0;
                    id_ex_en_c  = 1'b0;
                    ex_mem_en_c = 1'b0;
                    mem_wb_en_c = 1'b0;
                    halted_c    = 1'b1;
                    if (bus.resume) begin
                        state_d = S_RUN;
                    end
                end
                default: begin
                    state_d = S_RUN;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    // Saturating count of cycles the PC is held, excluding HALTED
    always_comb begin
        stall_d = stall_q;
        if (!pc_en_c && state_q != S_HALTED && stall_q != STALL_MAX) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    // State, countdown and stall counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            cnt_q   <= 8'd0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    // While in reset every stage is frozen and loaded with bubbles
    always_comb begin
        bus.pc_en        = rst_n & pc_en_c;
        bus.if_id_en     = rst_n & if_id_en_c;
        bus.id_ex_en     = rst_n & id_ex_en_c;
        bus.ex_mem_en    = rst_n & ex_mem_en_c;
        bus.mem_wb_en    = rst_n & mem_wb_en_c;
        bus.if_id_flush  = ~rst_n | if_id_fl_c;
        bus.id_ex_flush  = ~rst_n | id_ex_fl_c;
        bus.ex_mem_flush = ~rst_n | ex_mem_fl_c;
        bus.halted       = rst_n & halted_c;
        bus.stall_cycles = stall_q;
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed scenarios plus
// random traffic checked against a cycle-level behavioural model.
module tb_pipeline_ctrl;

    localparam int LAT  = 4;
    localparam int MAXS = 65535;

    logic clk;
    logic rst_n;

    pipeline_ctrl_if #(.CNT_W(16)) bus ();
    pipeline_ctrl_if #(.CNT_W(4))  bus2 ();

    pipeline_ctrl #(.MC_LATENCY(LAT), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    pipeline_ctrl #(.MC_LATENCY(LAT), .CNT_W(4)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    typedef struct packed {
        logic [4:0]  en;
        logic [2:0]  fl;
        logic        h;
        logic [15:0] st;
    } obs_t;

    typedef struct {
        obs_t  o;
        string tag;
    } item_t;

    item_t q1[$];
    item_t q2[$];
    int    total = 0;
    int    bad   = 0;

    // behavioural model state: EX cycles left for an MC op,
    // drain cycles left, halted flag, expected stall count
    int m_mc = 0;
    int m_dr = 0;
    bit m_h  = 0;
    int m_st = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t grab1();
        obs_t o;
        o.en = {bus.pc_en, bus.if_id_en, bus.id_ex_en,
                bus.ex_mem_en, bus.mem_wb_en};
        o.fl = {bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush};
        o.h  = bus.halted;
        o.st = bus.stall_cycles;
        return o;
    endfunction

    function automatic obs_t grab2();
        obs_t o;
        o.en = {bus2.pc_en, bus2.if_id_en, bus2.id_ex_en,
                bus2.ex_mem_en, bus2.mem_wb_en};
        o.fl = {bus2.if_id_flush, bus2.id_ex_flush, bus2.ex_mem_flush};
        o.h  = bus2.halted;
        o.st = {12'd0, bus2.stall_cycles};
        return o;
    endfunction

    task automatic cmp(input string tag, input obs_t got, input obs_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got en=%b fl=%b h=%b st=%0d want en=%b fl=%b h=%b st=%0d",
                     tag, got.en, got.fl, got.h, got.st,
                     exp.en, exp.fl, exp.h, exp.st);
        end
    endtask

    // Monitors: compare whatever the DUT presents this cycle
    always @(negedge clk) begin
        if (q1.size() > 0) begin
            item_t it;
            it = q1.pop_front();
            cmp(it.tag, grab1(), it.o);
        end
    end

    always @(negedge clk) begin
        if (q2.size() > 0) begin
            item_t it;
            it = q2.pop_front();
            cmp(it.tag, grab2(), it.o);
        end
    end

    // Reference: expected outputs for this cycle, then advance
    task automatic model(input bit r, lu, br, mc, hr, rs, mq, mr,
                         output obs_t e);
        bit was_h;
        e.en = 5'b11111;
        e.fl = 3'b000;
        e.h  = 1'b0;
        e.st = 16'(m_st);
        was_h = m_h;
        if (r) begin
            e.en = 5'b00000;
            e.fl = 3'b111;
            e.st = 16'd0;
            m_mc = 0;
            m_dr = 0;
            m_h  = 0;
            m_st = 0;
            return;
        end
        if (mq && !mr) begin
            e.en = 5'b00000;
            e.h  = m_h;
        end else if (m_h) begin
            e.en = 5'b00000;
            e.h  = 1'b1;
            if (rs) m_h = 0;
        end else if (m_dr > 0) begin
            e.en = 5'b01111;
            e.fl = 3'b110;
            m_dr--;
            if (m_dr == 0) m_h = 1;
        end else if (m_mc > 1) begin
            e.en = 5'b00011;
            e.fl = 3'b001;
            m_mc--;
        end else if (m_mc == 1) begin
            m_mc = 0;
        end else if (hr) begin
            e.en = 5'b01111;
            e.fl = 3'b110;
            m_dr = 2;
        end else if (mc) begin
            e.en = 5'b00011;
            e.fl = 3'b001;
            m_mc = LAT - 1;
        end else if (br) begin
            e.fl = 3'b110;
        end else if (lu) begin
            e.en = 5'b00111;
            e.fl = 3'b010;
        end
        if (!e.en[4] && !was_h && m_st < MAXS) m_st++;
    endtask

    task automatic step(input string tag,
                        input bit r, lu, br, mc, hr, rs, mq, mr);
        item_t it;
        @(posedge clk);
        #1;
        rst_n              = ~r;
        bus.load_use_stall = lu;
        bus.branch_taken   = br;
        bus.ex_mc_start    = mc;
        bus.halt_req       = hr;
        bus.resume         = rs;
        bus.mem_req        = mq;
        bus.mem_ready      = mr;
        model(r, lu, br, mc, hr, rs, mq, mr, it.o);
        it.tag = tag;
        q1.push_back(it);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.load_use_stall  = 0;
        bus.branch_taken    = 0;
        bus.ex_mc_start     = 0;
        bus.halt_req        = 0;
        bus.resume          = 0;
        bus.mem_req         = 0;
        bus.mem_ready       = 0;
        bus2.load_use_stall = 0;
        bus2.branch_taken   = 0;
        bus2.ex_mc_start    = 0;
        bus2.halt_req       = 0;
        bus2.resume         = 0;
        bus2.mem_req        = 0;
        bus2.mem_ready      = 0;

        step("reset_idle", 1, 0, 0, 0, 0, 0, 0, 0);
        step("reset_busy", 1, 1, 1, 1, 1, 1, 1, 0);
        idle("post_reset", 2);

        for (int i = 0; i < 20; i++) begin
            item_t it;
            @(posedge clk);
            #1;
            bus2.load_use_stall = 1'b1;
            it.o.en = 5'b00111;
            it.o.fl = 3'b010;
            it.o.h  = 1'b0;
            it.o.st = 16'((i < 15) ? i : 15);
            it.tag  = "sat_cntw4";
            q2.push_back(it);
        end
        @(posedge clk);
        #1;
        bus2.load_use_stall = 1'b0;

        step("mc_start", 0, 0, 0, 1, 0, 0, 0, 0);
        idle("mc_wait", 3);
        idle("mc_after", 1);

        step("br_lu", 0, 1, 1, 0, 0, 0, 0, 0);
        step("lu_only", 0, 1, 0, 0, 0, 0, 0, 0);
        idle("lu_after", 1);

        step("mcm_start", 0, 0, 0, 1, 0, 0, 0, 0);
        idle("mcm_wait", 1);
        for (int i = 0; i < 3; i++)
            step("mcm_memstall", 0, 1, 1, 1, 1, 1, 1, 0);
        step("mcm_memok", 0, 0, 0, 0, 0, 0, 1, 1);
        idle("mcm_tail", 3);

        step("halt_rst", 1, 0, 0, 0, 0, 0, 0, 0);
        idle("halt_rel", 1);
        step("halt_req", 0, 0, 0, 0, 1, 0, 0, 0);
        idle("drain", 2);
        for (int i = 0; i < 10; i++)
            step("halted", 0, 1, 1, 1, 1, 0, 0, 0);
        step("resume", 0, 0, 0, 0, 0, 1, 0, 0);
        idle("run_again", 2);

        step("rmc_start", 0, 0, 0, 1, 0, 0, 0, 0);
        idle("rmc_wait", 1);
        step("rmc_reset", 1, 0, 0, 0, 0, 0, 0, 0);
        idle("rmc_release", 1);
        step("rmc_run_lu", 0, 1, 0, 0, 0, 0, 0, 0);
        idle("rmc_base", 1);

        for (int i = 0; i < 400; i++) begin
            step("random",
                 ($urandom % 100) == 0,
                 ($urandom % 4) == 0,
                 ($urandom % 4) == 0,
                 ($urandom % 10) == 0,
                 ($urandom % 25) == 0,
                 ($urandom % 4) == 0,
                 ($urandom % 8) == 0,
                 ($urandom % 2) == 0);
        end

        for (int i = 0; i < 10 && (q1.size() + q2.size()) > 0; i++)
            @(posedge clk);
        if ((q1.size() + q2.size()) > 0) begin
            total++;
            bad++;
            $display("FAIL drain_queue: left=%0d want=0",
                     q1.size() + q2.size());
        end
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
